// File: rtl/axi4_pixel_ingress.sv
// Purpose : AXI4 write slave that buffers W beats as 256-bit pixel groups in a
//           first-word-fall-through FIFO and counts popped groups per frame.
// Ports   : AW/W/B AXI4 write channels (m_*), pg_* pixel-group stream out,
//           beat_cnt_o / frame_done_o frame progress. Clock ACLK_i, sync active-low ARESETn_i.
// Latency : a beat accepted at edge N is on pg_data_o after edge N if the FIFO was empty.
// Backpr. : WREADY drops while the FIFO is full; pg_ready_i low holds the head entry.
module axi4_pixel_ingress #(
    parameter int MST_ID_W         = 3,
    parameter int DATA_WIDTH       = 256,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_WR_RESP_W  = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int FRAME_BEATS      = 2400
) (
    input  logic                            ACLK_i,
    input  logic                            ARESETn_i,
    // write-address channel
    input  logic [MST_ID_W-1:0]             m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]           m_AWADDR_i,
    input  logic [TRANS_DATA_LEN_W-1:0]     m_AWLEN_i,
    input  logic                            m_AWVALID_i,
    output logic                            m_AWREADY_o,
    // write-data channel
    input  logic [DATA_WIDTH-1:0]           m_WDATA_i,
    input  logic                            m_WLAST_i,
    input  logic                            m_WVALID_i,
    output logic                            m_WREADY_o,
    // write-response channel
    output logic [MST_ID_W-1:0]             m_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]      m_BRESP_o,
    output logic                            m_BVALID_o,
    input  logic                            m_BREADY_i,
    // pixel-group stream
    output logic [DATA_WIDTH-1:0]           pg_data_o,
    output logic                            pg_valid_o,
    input  logic                            pg_ready_i,
    // frame progress
    output logic [$clog2(FRAME_BEATS)-1:0]  beat_cnt_o,
    output logic                            frame_done_o
);

    localparam int BC_W  = $clog2(FRAME_BEATS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [MST_ID_W-1:0]            id_q, id_d;
    logic [TRANS_DATA_LEN_W-1:0]    len_q, len_d;
    logic [TRANS_DATA_LEN_W-1:0]    bidx_q, bidx_d;
    logic                           err_q, err_d;

    logic                           aw_rdy, w_rdy, b_vld;
    logic                           beat_is_len;

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty
    logic [DATA_WIDTH-1:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W:0]                 wr_ptr_q, rd_ptr_q;
    logic                           fifo_full, fifo_empty;
    logic                           push, pop;

    logic [BC_W-1:0]                beat_cnt_q;
    logic                           frame_done_q;

    // The write address carries no information for a streaming sink.
    logic                           unused_awaddr;
    assign unused_awaddr = ^m_AWADDR_i;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign beat_is_len = (bidx_q == len_q);

    // Full blocks a push even when the head is popped in the same cycle,
    // keeping WREADY independent of pg_ready_i.
    assign push = m_WVALID_i & w_rdy;
    assign pop  = pg_valid_o & pg_ready_i;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        bidx_d  = bidx_q;
        err_d   = err_q;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        b_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                aw_rdy = ARESETn_i;
                if (m_AWVALID_i && aw_rdy) begin
                    id_d    = m_AWID_i;
                    len_d   = m_AWLEN_i;
                    bidx_d  = '0;
                    err_d   = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                w_rdy = ARESETn_i && !fifo_full;
                if (m_WVALID_i && w_rdy) begin
                    bidx_d = bidx_q + 1'b1;
                    // Either WLAST or the announced length closes the burst;
                    // disagreement between the two is a protocol error.
                    if (m_WLAST_i || beat_is_len) begin
                        err_d   = m_WLAST_i ^ beat_is_len;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                b_vld = ARESETn_i;
                if (m_BREADY_i && b_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            state_q      <= IDLE;
            id_q         <= '0;
            len_q        <= '0;
            bidx_q       <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            len_q        <= len_d;
            bidx_q       <= bidx_d;
            err_q        <= err_d;
            frame_done_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (beat_cnt_q == BC_W'(FRAME_BEATS - 1)) begin
                    beat_cnt_q   <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    beat_cnt_q   <= beat_cnt_q + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge ACLK_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= m_WDATA_i;
        end
    end

    // Outputs are forced to zero while reset is held so nothing stale leaks out.
    assign m_AWREADY_o  = aw_rdy;
    assign m_WREADY_o   = w_rdy;
    assign m_BVALID_o   = b_vld;
    assign m_BID_o      = b_vld ? id_q : '0;
    assign m_BRESP_o    = (b_vld && err_q) ? TRANS_WR_RESP_W'(2) : '0;
    assign pg_valid_o   = ARESETn_i & ~fifo_empty;
    assign pg_data_o    = pg_valid_o ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
    assign beat_cnt_o   = ARESETn_i ? beat_cnt_q : '0;
    assign frame_done_o = ARESETn_i & frame_done_q;

endmodule

// File: tb/tb_axi4_pixel_ingress.sv
module tb_axi4_pixel_ingress;

    localparam int IDW   = 3;
    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int LW    = 8;
    localparam int RW    = 2;
    localparam int DEPTH = 4;
    localparam int FB    = 2400;
    localparam int BCW   = $clog2(FB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [IDW-1:0]  awid;
    logic [AW-1:0]   awaddr;
    logic [LW-1:0]   awlen;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [IDW-1:0]  bid;
    logic [RW-1:0]   bresp;
    logic            bvalid;
    logic            bready;
    logic [DW-1:0]   pg_data;
    logic            pg_valid;
    logic            pg_ready = 1'b0;
    logic [BCW-1:0]  beat_cnt;
    logic            frame_done;

    axi4_pixel_ingress #(
        .MST_ID_W(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW),
        .TRANS_WR_RESP_W(RW), .FIFO_DEPTH(DEPTH), .FRAME_BEATS(FB)
    ) dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .m_AWID_i(awid), .m_AWADDR_i(awaddr), .m_AWLEN_i(awlen),
        .m_AWVALID_i(awvalid), .m_AWREADY_o(awready),
        .m_WDATA_i(wdata), .m_WLAST_i(wlast), .m_WVALID_i(wvalid), .m_WREADY_o(wready),
        .m_BID_o(bid), .m_BRESP_o(bresp), .m_BVALID_o(bvalid), .m_BREADY_i(bready),
        .pg_data_o(pg_data), .pg_valid_o(pg_valid), .pg_ready_i(pg_ready),
        .beat_cnt_o(beat_cnt), .frame_done_o(frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t: wait bound expired", nm, $time);
    endtask

    function automatic logic [DW-1:0] dat(input int n);
        logic [31:0] w;
        w = 32'hC0DE0000 + n;
        return {8{w}};
    endfunction

    // ---------------- behavioural model ----------------
    // Protocol phase: 0 waiting for address, 1 taking data, 2 responding.
    int            ms = 0;
    logic [DW-1:0] mq [$];
    int            m_id, m_len, m_idx, m_bc;
    bit            m_err, m_done;
    bit            cmp_en = 1'b0;

    always @(posedge clk) begin : model
        bit aw, w, b, pop, lastb, nd;
        if (!rst_n) begin
            ms = 0; mq.delete(); m_id = 0; m_len = 0; m_idx = 0;
            m_err = 0; m_bc = 0; m_done = 0; cmp_en = 1'b1;
        end else begin
            aw  = awvalid && ms == 0;
            w   = wvalid && ms == 1 && mq.size() < DEPTH;
            b   = bready && ms == 2;
            pop = mq.size() > 0 && pg_ready;
            nd  = 0;
            if (pop) begin
                void'(mq.pop_front());
                if (m_bc == FB - 1) begin m_bc = 0; nd = 1; end
                else m_bc++;
            end
            if (w) begin
                mq.push_back(wdata);
                lastb = (m_idx == m_len);
                if (wlast || lastb) begin
                    m_err = (wlast != lastb);
                    ms = 2;
                end
                m_idx++;
            end
            if (aw) begin m_id = awid; m_len = awlen; m_idx = 0; m_err = 0; ms = 1; end
            if (b) ms = 0;
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("awready",    awready,    rst_n && ms == 0);
            chk("wready",     wready,     rst_n && ms == 1 && mq.size() < DEPTH);
            chk("bvalid",     bvalid,     rst_n && ms == 2);
            chk("bid",        bid,        (rst_n && ms == 2) ? m_id : 0);
            chk("bresp",      bresp,      (rst_n && ms == 2 && m_err) ? 2 : 0);
            chk("pg_valid",   pg_valid,   rst_n && mq.size() > 0);
            chk("pg_data",    pg_data,    (rst_n && mq.size() > 0) ? mq[0] : '0);
            chk("beat_cnt",   beat_cnt,   rst_n ? m_bc : 0);
            chk("frame_done", frame_done, rst_n && m_done);
        end
    end

    // ---------------- pop capture ----------------
    logic [DW-1:0] got [$];
    int            n_done = 0;
    always @(negedge clk) begin
        if (cmp_en && rst_n && pg_valid && pg_ready) got.push_back(pg_data);
        if (cmp_en && frame_done) n_done++;
    end

    // 0: consumer stalled, 1: always ready, 2: random
    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       pg_ready = 1'b0;
            1:       pg_ready = 1'b1;
            default: pg_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input int id, input int len);
        bit ok;
        ok = 0;
        awid = IDW'(id); awlen = LW'(len); awaddr = $urandom; awvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_wait");
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input bit last);
        bit ok;
        ok = 0;
        wdata = d; wlast = last; wvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        if (!ok) timeout("w_wait");
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    // Waits for the response, holds BREADY low two cycles to see it stay put.
    task automatic b_wait(input int exp_id, input int exp_resp);
        bit ok;
        ok = 0;
        bready = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        if (!ok) timeout("b_wait");
        chk("bid_lit",   bid,   exp_id);
        chk("bresp_lit", bresp, exp_resp);
        tick();
        @(negedge clk);
        chk("bvalid_held", bvalid, 1'b1);
        chk("bresp_held",  bresp,  exp_resp);
        tick();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic drain(input int n, input int bound);
        bit ok;
        ok = 0;
        for (int t = 0; t < bound; t++) begin
            if (got.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) timeout("drain");
    endtask

    task automatic chk_got(input string nm, input int base, input int n);
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk(nm, got[i], dat(base + i));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; awvalid = 1'b1; awid = 3'd7; awlen = '0; awaddr = '0;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0;

        // reset with AWVALID held: no handshake
        repeat (4) begin
            @(negedge clk);
            chk("rst_awready", awready, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; awvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", awready,  1'b1);
        chk("post_rst_wready",  wready,   1'b0);
        chk("post_rst_bvalid",  bvalid,   1'b0);
        chk("post_rst_pgvalid", pg_valid, 1'b0);
        chk("post_rst_pgdata",  pg_data,  '0);
        chk("post_rst_bcnt",    beat_cnt, 0);
        tick();

        // basic 4-beat burst
        rdy_mode = 1; tick(); got.delete();
        aw_send(3, 3);
        for (int i = 0; i < 4; i++) w_send(dat(i), i == 3);
        b_wait(3, 0);
        drain(4, 50);
        chk_got("basic", 0, 4);

        // backpressure: FIFO fills after four beats
        rdy_mode = 0; tick(); got.delete();
        aw_send(5, 7);
        for (int i = 0; i < 4; i++) w_send(dat(10 + i), 1'b0);
        wdata = dat(14); wvalid = 1'b1;
        @(negedge clk);
        chk("full_wready", wready, 1'b0);
        tick();
        @(negedge clk);
        chk("full_wready2", wready, 1'b0);
        rdy_mode = 1;
        for (int i = 4; i < 8; i++) w_send(dat(10 + i), i == 7);
        b_wait(5, 0);
        drain(8, 50);
        chk_got("bp", 10, 8);

        // early WLAST
        got.delete();
        aw_send(1, 7);
        for (int i = 0; i < 3; i++) w_send(dat(20 + i), i == 2);
        b_wait(1, 2);
        @(negedge clk);
        chk("idle_after_err", awready, 1'b1);
        drain(3, 50);
        chk_got("early_last", 20, 3);

        // missing WLAST
        tick(); got.delete();
        aw_send(2, 1);
        w_send(dat(30), 1'b0);
        w_send(dat(31), 1'b0);
        b_wait(2, 2);
        drain(2, 50);
        chk_got("no_last", 30, 2);

        // reset mid-burst
        rdy_mode = 0; tick(); got.delete();
        aw_send(4, 7);
        w_send(dat(35), 1'b0);
        w_send(dat(36), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pgvalid", pg_valid, 1'b0);
        chk("midrst_bvalid",  bvalid,   1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_awready", awready,  1'b1);
        chk("midrst_pgvalid2", pg_valid, 1'b0);
        rdy_mode = 1; tick();
        aw_send(6, 1);
        w_send(dat(40), 1'b0);
        w_send(dat(41), 1'b1);
        b_wait(6, 0);
        drain(2, 50);
        chk_got("after_rst", 40, 2);

        // full frame across ten bursts with random consumer
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        chk("frame_bcnt_start", beat_cnt, 0);
        rdy_mode = 2; got.delete(); n_done = 0;
        for (int b = 0; b < 10; b++) begin
            aw_send(b % 8, 239);
            for (int i = 0; i < 240; i++) w_send(dat(1000 + b * 240 + i), i == 239);
            b_wait(b % 8, 0);
        end
        drain(FB, 2000);
        rdy_mode = 1;
        repeat (4) tick();
        chk("frame_pops", got.size(), FB);
        chk("frame_done_pulses", n_done, 1);
        chk("frame_bcnt_end", beat_cnt, 0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < got.size(); i++) if (got[i] !== dat(1000 + i)) bad++;
            chk("frame_order_errors", bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
